// File: rtl/vram_pkg.sv
// Shared constants and types for the VRAM arbiter: display timing limits,
// line geometry and the arbiter state encoding.
package vram_pkg;

    localparam logic [9:0] H_ACTIVE       = 10'd640;
    localparam logic [9:0] V_TOTAL        = 10'd525;
    localparam logic [9:0] V_ACTIVE       = 10'd480;
    localparam int         WORDS_PER_LINE = 80;
    localparam int         VRAM_AW        = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_e;

endpackage

// File: rtl/vram_arb_if.sv
// Bus bundle between the VRAM arbiter and its environment: timing inputs,
// draw/CPU request ports, memory port and line-buffer write port.
interface vram_arb_if;
    import vram_pkg::*;

    logic                PCK;
    logic [9:0]          HCNT;
    logic [9:0]          VCNT;
    logic                D_REQ;
    logic                C_REQ;
    logic [VRAM_AW-1:0]  D_ADR;
    logic [VRAM_AW-1:0]  C_ADR;
    logic [15:0]         D_WDATA;
    logic [15:0]         C_WDATA;
    logic                D_WE;
    logic                C_WE;
    logic                D_ACK;
    logic                C_ACK;
    logic                D_RVALID;
    logic [15:0]         D_RDATA;
    logic                C_RVALID;
    logic [15:0]         C_RDATA;
    logic                MEM_EN;
    logic                MEM_WE;
    logic [VRAM_AW-1:0]  MEM_ADR;
    logic [15:0]         MEM_WDATA;
    logic [15:0]         MEM_RDATA;
    logic                LB_WE;
    logic [6:0]          LB_WADR;
    logic [15:0]         LB_WDATA;
    logic                LB_BANK;
    logic                FETCH_BUSY;

    modport master (
        output PCK, HCNT, VCNT, D_REQ, C_REQ, D_ADR, C_ADR, D_WDATA, C_WDATA,
               D_WE, C_WE, MEM_RDATA,
        input  D_ACK, C_ACK, D_RVALID, D_RDATA, C_RVALID, C_RDATA, MEM_EN,
               MEM_WE, MEM_ADR, MEM_WDATA, LB_WE, LB_WADR, LB_WDATA, LB_BANK,
               FETCH_BUSY
    );

    // The pixel clock is not needed by the arbiter itself; HCNT edges suffice.
    modport slave (
        input  HCNT, VCNT, D_REQ, C_REQ, D_ADR, C_ADR, D_WDATA, C_WDATA,
               D_WE, C_WE, MEM_RDATA,
        output D_ACK, C_ACK, D_RVALID, D_RDATA, C_RVALID, C_RDATA, MEM_EN,
               MEM_WE, MEM_ADR, MEM_WDATA, LB_WE, LB_WADR, LB_WDATA, LB_BANK,
               FETCH_BUSY
    );

endinterface

// File: rtl/vram_rrarb.sv
// Two-way round-robin arbiter between the draw engine and the CPU; on a tie
// the requester not served most recently wins.
module vram_rrarb (
    input  logic CLK,
    input  logic RST,
    input  logic en,
    input  logic d_req,
    input  logic c_req,
    output logic gnt_d,
    output logic gnt_c
);

    logic last_c_q, last_c_d;

    // Grant selection and last-served pointer update
    always_comb begin
        gnt_d    = 1'b0;
        gnt_c    = 1'b0;
        last_c_d = last_c_q;
        if (en && d_req && c_req) begin
            gnt_d    = last_c_q;
            gnt_c    = !last_c_q;
            last_c_d = !last_c_q;
        end else if (en && d_req) begin
            gnt_d    = 1'b1;
            last_c_d = 1'b0;
        end else if (en && c_req) begin
            gnt_c    = 1'b1;
            last_c_d = 1'b1;
        end else begin
            last_c_d = last_c_q;
        end
    end

    // Pointer register; after reset the CPU counts as last served
    always_ff @(posedge CLK) begin
        if (!RST) begin
            last_c_q <= 1'b1;
        end else begin
            last_c_q <= last_c_d;
        end
    end

endmodule

// File: rtl/vram_arb.sv
// VRAM arbiter: display line fetch bursts preempt the draw engine and CPU,
// which otherwise share the memory port round-robin, one access per clock.
module vram_arb
    import vram_pkg::*;
(
    input  logic      CLK,
    input  logic      RST,
    vram_arb_if.slave bus
);

    localparam logic [6:0]         LAST_IDX    = 7'(WORDS_PER_LINE - 1);
    localparam logic [VRAM_AW-1:0] LINE_STRIDE = VRAM_AW'(WORDS_PER_LINE);

    state_e             state_q, state_d;
    logic [6:0]         idx_q, idx_d;
    logic [VRAM_AW-1:0] base_q, base_d;
    logic               hcnt_eq_q, hcnt_eq_d;
    logic               busy_q, busy_d;
    logic               mem_en_q, mem_en_d, mem_we_q, mem_we_d;
    logic [VRAM_AW-1:0] mem_adr_q, mem_adr_d;
    logic [15:0]        mem_wdata_q, mem_wdata_d;
    logic               d_ack_q, d_ack_d, c_ack_q, c_ack_d;
    logic               d_rvalid_q, d_rvalid_d, c_rvalid_q, c_rvalid_d;
    logic [15:0]        d_rdata_q, d_rdata_d, c_rdata_q, c_rdata_d;
    logic               lb_we_q, lb_we_d, lb_bank_q, lb_bank_d;
    logic [6:0]         lb_wadr_q, lb_wadr_d;
    logic [15:0]        lb_wdata_q, lb_wdata_d;

    logic               hcnt_eq_s, vcnt_ok_s, trig_s, arb_en_s, gnt_d_s, gnt_c_s;
    logic [9:0]         line_s;
    logic [VRAM_AW-1:0] base_new_s;

    // Fetch trigger is the rising edge of the HCNT==640 compare
    assign hcnt_eq_s  = (bus.HCNT == H_ACTIVE);
    assign vcnt_ok_s  = (bus.VCNT < (V_ACTIVE - 10'd1)) || (bus.VCNT == (V_TOTAL - 10'd1));
    assign trig_s     = hcnt_eq_s && !hcnt_eq_q && vcnt_ok_s && (state_q == IDLE);
    assign line_s     = (bus.VCNT == (V_TOTAL - 10'd1)) ? 10'd0 : (bus.VCNT + 10'd1);
    assign base_new_s = (line_s == 10'd0) ? {VRAM_AW{1'b0}} : (base_q + LINE_STRIDE);
    assign arb_en_s   = (state_q == IDLE) && !trig_s;

    vram_rrarb u_rrarb (
        .CLK   (CLK),
        .RST   (RST),
        .en    (arb_en_s),
        .d_req (bus.D_REQ && !d_ack_q),
        .c_req (bus.C_REQ && !c_ack_q),
        .gnt_d (gnt_d_s),
        .gnt_c (gnt_c_s)
    );

    // Next-state, bus mux and read-return steering
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        base_d      = base_q;
        hcnt_eq_d   = hcnt_eq_s;
        busy_d      = busy_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_adr_d   = mem_adr_q;
        mem_wdata_d = mem_wdata_q;
        d_ack_d     = 1'b0;
        c_ack_d     = 1'b0;
        lb_bank_d   = lb_bank_q;
        // Each FETCH cycle has a read on the bus whose data returns now
        lb_we_d     = (state_q == FETCH);
        lb_wadr_d   = lb_we_d ? idx_q : lb_wadr_q;
        lb_wdata_d  = lb_we_d ? bus.MEM_RDATA : lb_wdata_q;
        d_rvalid_d  = d_ack_q && !mem_we_q;
        d_rdata_d   = d_rvalid_d ? bus.MEM_RDATA : d_rdata_q;
        c_rvalid_d  = c_ack_q && !mem_we_q;
        c_rdata_d   = c_rvalid_d ? bus.MEM_RDATA : c_rdata_q;
        case (state_q)
            IDLE: begin
                if (trig_s) begin
                    state_d   = FETCH;
                    busy_d    = 1'b1;
                    idx_d     = 7'd0;
                    base_d    = base_new_s;
                    lb_bank_d = line_s[0];
                    mem_en_d  = 1'b1;
                    mem_adr_d = base_new_s;
                end else if (gnt_d_s) begin
                    mem_en_d    = 1'b1;
                    mem_we_d    = bus.D_WE;
                    mem_adr_d   = bus.D_ADR;
                    mem_wdata_d = bus.D_WDATA;
                    d_ack_d     = 1'b1;
                end else if (gnt_c_s) begin
                    mem_en_d    = 1'b1;
                    mem_we_d    = bus.C_WE;
                    mem_adr_d   = bus.C_ADR;
                    mem_wdata_d = bus.C_WDATA;
                    c_ack_d     = 1'b1;
                end else begin
                    mem_en_d = 1'b0;
                end
            end
            FETCH: begin
                if (idx_q == LAST_IDX) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    idx_d     = idx_q + 7'd1;
                    mem_en_d  = 1'b1;
                    mem_adr_d = base_q + {9'd0, idx_d};
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q     <= IDLE;
            idx_q       <= 7'd0;
            base_q      <= {VRAM_AW{1'b0}};
            hcnt_eq_q   <= 1'b0;
            busy_q      <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_adr_q   <= {VRAM_AW{1'b0}};
            mem_wdata_q <= 16'd0;
            d_ack_q     <= 1'b0;
            c_ack_q     <= 1'b0;
            d_rvalid_q  <= 1'b0;
            c_rvalid_q  <= 1'b0;
            d_rdata_q   <= 16'd0;
            c_rdata_q   <= 16'd0;
            lb_we_q     <= 1'b0;
            lb_wadr_q   <= 7'd0;
            lb_wdata_q  <= 16'd0;
            lb_bank_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            base_q      <= base_d;
            hcnt_eq_q   <= hcnt_eq_d;
            busy_q      <= busy_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_adr_q   <= mem_adr_d;
            mem_wdata_q <= mem_wdata_d;
            d_ack_q     <= d_ack_d;
            c_ack_q     <= c_ack_d;
            d_rvalid_q  <= d_rvalid_d;
            c_rvalid_q  <= c_rvalid_d;
            d_rdata_q   <= d_rdata_d;
            c_rdata_q   <= c_rdata_d;
            lb_we_q     <= lb_we_d;
            lb_wadr_q   <= lb_wadr_d;
            lb_wdata_q  <= lb_wdata_d;
            lb_bank_q   <= lb_bank_d;
        end
    end

    assign bus.MEM_EN     = mem_en_q;
    assign bus.MEM_WE     = mem_we_q;
    assign bus.MEM_ADR    = mem_adr_q;
    assign bus.MEM_WDATA  = mem_wdata_q;
    assign bus.D_ACK      = d_ack_q;
    assign bus.C_ACK      = c_ack_q;
    assign bus.D_RVALID   = d_rvalid_q;
    assign bus.D_RDATA    = d_rdata_q;
    assign bus.C_RVALID   = c_rvalid_q;
    assign bus.C_RDATA    = c_rdata_q;
    assign bus.LB_WE      = lb_we_q;
    assign bus.LB_WADR    = lb_wadr_q;
    assign bus.LB_WDATA   = lb_wdata_q;
    assign bus.LB_BANK    = lb_bank_q;
    assign bus.FETCH_BUSY = busy_q;

endmodule

// File: tb/tb_vram_arb.sv
// Scoreboard bench for vram_arb: stimulus pushes expected bus accesses,
// line-buffer writes and read data; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_vram_arb;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;
    int   lb_count    = 0;
    int   burst_count = 0;
    logic busy_prev   = 1'b0;

    logic [34:0] exp_mem[$];   // {src(0 fetch,1 draw,2 cpu), we, adr, wdata}
    logic [23:0] exp_lb[$];    // {bank, wadr, wdata}
    logic [15:0] exp_crd[$];
    logic [15:0] exp_drd[$];

    logic [1:0]  mon_src;
    logic [34:0] mon_mem;
    logic [23:0] mon_lb;

    vram_arb_if bus();

    vram_arb dut (
        .CLK (clk),
        .RST (rst_n),
        .bus (bus)
    );

    always #10 clk = ~clk;

    initial begin
        bus.PCK = 1'b0;
        forever #20 bus.PCK = ~bus.PCK;
    end

    function automatic logic [15:0] mem_val(input logic [15:0] a);
        return a ^ 16'h5A3C;
    endfunction

    function automatic logic [34:0] mrec(input logic [1:0] s, input logic we,
                                         input logic [15:0] a, input logic [15:0] wd);
        return {s, we, a, wd};
    endfunction

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Asynchronous-read memory model: data for a read on the bus is ready by the next edge
    always @(negedge clk) begin
        bus.MEM_RDATA = (bus.MEM_EN && !bus.MEM_WE) ? mem_val(bus.MEM_ADR) : 16'h0000;
    end

    // Monitor: every DUT event is matched against the head of its queue
    always @(negedge clk) begin
        if (bus.MEM_EN === 1'b1) begin
            mon_src = bus.D_ACK ? 2'd1 : (bus.C_ACK ? 2'd2 : 2'd0);
            mon_mem = mrec(mon_src, bus.MEM_WE, bus.MEM_ADR, bus.MEM_WE ? bus.MEM_WDATA : 16'h0000);
            if (exp_mem.size() == 0) begin
                check("mem_unexpected", {5'd0, mon_mem}, 40'hFF_FFFF_FFFF);
            end else begin
                check("mem_access", {5'd0, mon_mem}, {5'd0, exp_mem.pop_front()});
            end
        end else if ((bus.D_ACK === 1'b1) || (bus.C_ACK === 1'b1)) begin
            check("ack_without_mem_en", 40'd1, 40'd0);
        end
        if (bus.LB_WE === 1'b1) begin
            lb_count++;
            mon_lb = {bus.LB_BANK, bus.LB_WADR, bus.LB_WDATA};
            if (exp_lb.size() == 0) check("lb_unexpected", {16'd0, mon_lb}, 40'hFF_FFFF_FFFF);
            else                    check("lb_write", {16'd0, mon_lb}, {16'd0, exp_lb.pop_front()});
        end
        if (bus.C_RVALID === 1'b1) begin
            if (exp_crd.size() == 0) check("c_rvalid_unexpected", {24'd0, bus.C_RDATA}, 40'hFF_FFFF_FFFF);
            else                     check("c_rdata", {24'd0, bus.C_RDATA}, {24'd0, exp_crd.pop_front()});
        end
        if (bus.D_RVALID === 1'b1) begin
            if (exp_drd.size() == 0) check("d_rvalid_unexpected", {24'd0, bus.D_RDATA}, 40'hFF_FFFF_FFFF);
            else                     check("d_rdata", {24'd0, bus.D_RDATA}, {24'd0, exp_drd.pop_front()});
        end
        if ((bus.FETCH_BUSY === 1'b1) && !busy_prev) burst_count++;
        busy_prev = (bus.FETCH_BUSY === 1'b1);
    end

    // One display line: HCNT 639->640 at VCNT=v, optional requester read injected mid-burst
    task automatic run_line(input logic [9:0] v, input int inj, input logic [15:0] iadr);
        logic        fetch;
        logic [9:0]  l;
        logic [15:0] base;
        int          ack_n;
        fetch = (v < 10'd479) || (v == 10'd524);
        l     = (v == 10'd524) ? 10'd0 : (v + 10'd1);
        base  = 16'(l) * 16'd80;
        bus.VCNT = v;
        bus.HCNT = 10'd639;
        @(negedge clk);
        bus.HCNT = 10'd640;
        if (fetch) begin
            for (int i = 0; i < 80; i++) begin
                exp_mem.push_back(mrec(2'd0, 1'b0, base + 16'(i), 16'h0000));
                exp_lb.push_back({l[0], 7'(i), mem_val(base + 16'(i))});
            end
        end
        ack_n = -1;
        for (int n = 1; n <= 86; n++) begin
            @(negedge clk);
            if (n == 1)             check("busy_start", {39'd0, bus.FETCH_BUSY}, {39'd0, fetch});
            if (n == 80 && fetch)   check("busy_last_read", {39'd0, bus.FETCH_BUSY}, 40'd1);
            if (n == 81)            check("busy_end", {39'd0, bus.FETCH_BUSY}, 40'd0);
            if (n == 20 && inj == 1) begin
                bus.C_REQ = 1'b1; bus.C_WE = 1'b0; bus.C_ADR = iadr;
                exp_mem.push_back(mrec(2'd2, 1'b0, iadr, 16'h0000));
                exp_crd.push_back(mem_val(iadr));
            end
            if (n == 20 && inj == 2) begin
                bus.D_REQ = 1'b1; bus.D_WE = 1'b0; bus.D_ADR = iadr;
                exp_mem.push_back(mrec(2'd1, 1'b0, iadr, 16'h0000));
                exp_drd.push_back(mem_val(iadr));
            end
            if (bus.C_REQ && bus.C_ACK) begin ack_n = n; bus.C_REQ = 1'b0; end
            if (bus.D_REQ && bus.D_ACK) begin ack_n = n; bus.D_REQ = 1'b0; end
        end
        if (inj != 0) check("held_req_ack_cycle", 40'(ack_n), 40'd82);
        bus.HCNT = 10'd0;
        @(negedge clk);
    endtask

    initial begin
        int dn, cn, first, last, ack_cycles, found, lb_frame, burst_frame;
        bus.HCNT = 10'd0;   bus.VCNT = 10'd0;
        bus.D_REQ = 1'b0;   bus.C_REQ = 1'b0;
        bus.D_ADR = 16'h0;  bus.C_ADR = 16'h0;
        bus.D_WDATA = 16'h0; bus.C_WDATA = 16'h0;
        bus.D_WE = 1'b0;    bus.C_WE = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mem_en",  {39'd0, bus.MEM_EN},     40'd0);
        check("rst_busy",    {39'd0, bus.FETCH_BUSY}, 40'd0);
        check("rst_lb_we",   {39'd0, bus.LB_WE},      40'd0);
        check("rst_acks",    {38'd0, bus.D_ACK, bus.C_ACK}, 40'd0);
        check("rst_mem_adr", {24'd0, bus.MEM_ADR},    40'd0);
        check("rst_lb_data", {16'd0, bus.LB_BANK, bus.LB_WADR, bus.LB_WDATA}, 40'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Uncontended draw write: ACK in the cycle after REQ is first sampled
        bus.D_REQ = 1'b1; bus.D_WE = 1'b1; bus.D_ADR = 16'h0100; bus.D_WDATA = 16'hBEEF;
        exp_mem.push_back(mrec(2'd1, 1'b1, 16'h0100, 16'hBEEF));
        @(negedge clk);
        check("d_grant_latency", {39'd0, bus.D_ACK}, 40'd1);
        bus.D_REQ = 1'b0;
        @(negedge clk);

        // Uncontended CPU read
        bus.C_REQ = 1'b1; bus.C_WE = 1'b0; bus.C_ADR = 16'h0042;
        exp_mem.push_back(mrec(2'd2, 1'b0, 16'h0042, 16'h0000));
        exp_crd.push_back(mem_val(16'h0042));
        @(negedge clk);
        check("c_grant_latency", {39'd0, bus.C_ACK}, 40'd1);
        bus.C_REQ = 1'b0;
        repeat (3) @(negedge clk);

        // Both held: D,C,D,C at one grant per clock
        bus.D_ADR = 16'h0200; bus.D_WE = 1'b1; bus.D_WDATA = 16'h1111;
        bus.C_ADR = 16'h0300; bus.C_WE = 1'b1; bus.C_WDATA = 16'h2222;
        bus.D_REQ = 1'b1; bus.C_REQ = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_mem.push_back(mrec(2'd1, 1'b1, 16'h0200, 16'h1111));
            exp_mem.push_back(mrec(2'd2, 1'b1, 16'h0300, 16'h2222));
        end
        dn = 0; cn = 0; first = -1; last = -1; ack_cycles = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (bus.D_ACK || bus.C_ACK) begin
                ack_cycles++;
                if (first < 0) first = n;
                last = n;
            end
            if (bus.D_REQ && bus.D_ACK) begin dn++; if (dn == 4) bus.D_REQ = 1'b0; end
            if (bus.C_REQ && bus.C_ACK) begin cn++; if (cn == 4) bus.C_REQ = 1'b0; end
        end
        check("rr_d_count",    40'(dn), 40'd4);
        check("rr_c_count",    40'(cn), 40'd4);
        check("rr_first_ack",  40'(first), 40'd1);
        check("rr_span",       40'(last - first), 40'd7);
        check("rr_ack_cycles", 40'(ack_cycles), 40'd8);
        bus.D_WE = 1'b0; bus.C_WE = 1'b0;
        repeat (2) @(negedge clk);

        // Full frame, VCNT=524 first so the accumulated base starts from line 0
        lb_count = 0; burst_count = 0;
        run_line(10'd524, 0, 16'h0000);
        for (int v = 0; v < 524; v++) begin
            run_line(10'(v), (v == 10) ? 1 : ((v == 200) ? 2 : 0),
                     (v == 10) ? 16'h1234 : 16'h0777);
        end
        lb_frame = lb_count; burst_frame = burst_count;
        check("frame_bursts",    40'(burst_frame), 40'd480);
        check("frame_lb_writes", 40'(lb_frame), 40'd38400);

        // Reset at idx 40 aborts the burst including the pending line-buffer write
        bus.VCNT = 10'd524; bus.HCNT = 10'd639;
        @(negedge clk);
        bus.HCNT = 10'd640;
        for (int i = 0; i <= 40; i++) exp_mem.push_back(mrec(2'd0, 1'b0, 16'(i), 16'h0000));
        for (int i = 0; i < 40; i++)  exp_lb.push_back({1'b0, 7'(i), mem_val(16'(i))});
        found = 0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (bus.MEM_EN && (bus.MEM_ADR == 16'd40)) begin
                found = 1;
                rst_n = 1'b0;
                bus.HCNT = 10'd0;
                break;
            end
        end
        check("abort_reached_idx40", 40'(found), 40'd1);
        @(negedge clk);
        check("abort_busy",   {39'd0, bus.FETCH_BUSY}, 40'd0);
        check("abort_lb_we",  {39'd0, bus.LB_WE},      40'd0);
        check("abort_mem_en", {39'd0, bus.MEM_EN},     40'd0);
        rst_n = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            check("abort_quiet_mem_en", {39'd0, bus.MEM_EN}, 40'd0);
        end

        check("mem_queue_drained", 40'(exp_mem.size()), 40'd0);
        check("lb_queue_drained",  40'(exp_lb.size()),  40'd0);
        check("crd_queue_drained", 40'(exp_crd.size()), 40'd0);
        check("drd_queue_drained", 40'(exp_drd.size()), 40'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
